// File: rtl/jtframe_ram_nslots_arb.sv
// jtframe_ram_nslots_arb
// ----------------------
// Purpose: collects read/write requests from SLOTS requesters and presents one
// of them at a time to the SDRAM controller. A grant is held until the
// controller signals data_rdy. The winner is picked by fixed priority (lowest
// index) or by round-robin, slots 0..WRSLOTS-1 may write, and an optional
// watchdog drops a grant that never sees data_rdy.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   slot_req/rnw        per-slot request level and read(1)/write(0) flag
//   slot_addr/din/wrmask per-slot address, write data, byte mask (active low)
//   slot_sel            one-hot grant back to the requesters
//   sdram_ack           controller took the command (clears the strobes)
//   data_rdy            controller finished the access (ends the grant)
//   sdram_rd/wr         command strobes
//   sdram_addr          command address
//   data_write          write data
//   sdram_wrmask        byte mask, active low
//   timeout             one-cycle pulse when the watchdog drops a grant
//   timeout_slot        index of the last slot dropped by the watchdog
// All outputs are registered.
module jtframe_ram_nslots_arb #(
  parameter int SLOTS   = 8,
  parameter int SDRAMW  = 22,
  parameter int WRSLOTS = 2,
  parameter int RR      = 0,
  parameter int TIMEOUT = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SLOTS-1:0]          slot_req,
  input  logic [SLOTS-1:0]          slot_rnw,
  input  logic [SLOTS*SDRAMW-1:0]   slot_addr,
  input  logic [SLOTS*16-1:0]       slot_din,
  input  logic [SLOTS*2-1:0]        slot_wrmask,
  output logic [SLOTS-1:0]          slot_sel,
  input  logic                      sdram_ack,
  input  logic                      data_rdy,
  output logic                      sdram_rd,
  output logic                      sdram_wr,
  output logic [SDRAMW-1:0]         sdram_addr,
  output logic [15:0]               data_write,
  output logic [1:0]                sdram_wrmask,
  output logic                      timeout,
  output logic [$clog2(SLOTS)-1:0]  timeout_slot
);

  localparam int IDXW = $clog2(SLOTS);
  // Last counter value before the watchdog fires; unused when TIMEOUT==0.
  localparam logic [15:0] CNT_LAST = 16'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Registered state
  logic [SLOTS-1:0]  sel_q,     sel_d;
  logic              rd_q,      rd_d;
  logic              wr_q,      wr_d;
  logic [SDRAMW-1:0] addr_q,    addr_d;
  logic [15:0]       dout_q,    dout_d;
  logic [1:0]        mask_q,    mask_d;
  logic              to_q,      to_d;
  logic [IDXW-1:0]   to_slot_q, to_slot_d;
  logic [IDXW-1:0]   ptr_q,     ptr_d;
  logic [IDXW-1:0]   cur_q,     cur_d;
  logic [15:0]       cnt_q,     cnt_d;

  // Arbitration helpers
  logic [SLOTS-1:0]  active;
  logic              busy;
  logic              arb_pt;
  logic              wd_hit;
  logic              found;
  logic [IDXW-1:0]   win;

  // Grant candidate fields for the winner
  logic [SLOTS-1:0]  g_sel;
  logic [SDRAMW-1:0] g_addr;
  logic [15:0]       g_din;
  logic [1:0]        g_mask;
  logic              g_rd;
  logic              g_wr;

  // Data/mask inputs of read-only slots and the pointer in fixed mode are
  // legitimately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{slot_din, slot_wrmask, slot_rnw, ptr_q};

  // Winner search. Each active slot gets a distance from the search start:
  // its index in fixed mode, or its offset from ptr+1 (mod SLOTS) in
  // round-robin mode. The smallest distance wins. Only constant indices are
  // used so the loop unrolls into a plain priority tree.
  function automatic logic [IDXW:0] pick(input logic [SLOTS-1:0] act,
                                         input logic [IDXW-1:0]  ptr);
    logic            hit;
    logic [IDXW-1:0] best;
    int              best_d;
    int              d;
    hit    = 1'b0;
    best   = '0;
    best_d = SLOTS;
    for (int i = 0; i < SLOTS; i++) begin
      if (RR != 0) d = (i + 2 * SLOTS - int'(ptr) - 1) % SLOTS;
      else         d = i;
      if (act[i] && (d < best_d)) begin
        hit    = 1'b1;
        best   = IDXW'(i);
        best_d = d;
      end
    end
    return {hit, best};
  endfunction

  // The slot that just finished is masked so it cannot win on the same
  // data_rdy cycle that ends its own access.
  assign active = slot_req & ~sel_q;
  assign busy   = |sel_q;
  assign arb_pt = !busy || data_rdy;
  assign wd_hit = (TIMEOUT > 0) && busy && !data_rdy && (cnt_q == CNT_LAST);

  assign {found, win} = pick(active, ptr_q);

  // Build the command the winner would issue. With no winner everything
  // defaults to idle and data_write keeps its previous value.
  always_comb begin
    g_sel  = '0;
    g_addr = addr_q;
    g_din  = dout_q;
    g_mask = 2'b11;
    g_rd   = 1'b0;
    g_wr   = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (found && (win == IDXW'(i))) begin
        g_sel[i] = 1'b1;
        g_addr   = slot_addr[i*SDRAMW +: SDRAMW];
        if (i < WRSLOTS) begin
          g_din  = slot_din[i*16 +: 16];
          g_mask = slot_wrmask[i*2 +: 2];
          g_rd   = slot_rnw[i];
          g_wr   = ~slot_rnw[i];
        end else begin
          // Read-only slot: rnw/din/wrmask are ignored.
          g_rd   = 1'b1;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    sel_d     = sel_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    mask_d    = mask_q;
    to_d      = 1'b0;
    to_slot_d = to_slot_q;
    ptr_d     = ptr_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;

    if (sdram_ack) begin
      rd_d = 1'b0;
      wr_d = 1'b0;
    end

    if (busy)     cnt_d = cnt_q + 16'd1;
    if (data_rdy) cnt_d = '0;

    if (arb_pt) begin
      // A new grant's strobes override a same-cycle sdram_ack.
      sel_d = g_sel;
      rd_d  = g_rd;
      wr_d  = g_wr;
      if (found) begin
        addr_d = g_addr;
        dout_d = g_din;
        mask_d = g_mask;
        cur_d  = win;
        cnt_d  = '0;
        if (RR != 0) ptr_d = win;
      end
    end else if (wd_hit) begin
      // Drop the stuck grant; ptr is left alone so fairness is unaffected.
      sel_d     = '0;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      to_d      = 1'b1;
      to_slot_d = cur_q;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      mask_q    <= 2'b11;
      to_q      <= 1'b0;
      to_slot_q <= '0;
      ptr_q     <= IDXW'(SLOTS - 1);
      cur_q     <= '0;
      cnt_q     <= '0;
    end else begin
      sel_q     <= sel_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      mask_q    <= mask_d;
      to_q      <= to_d;
      to_slot_q <= to_slot_d;
      ptr_q     <= ptr_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
    end
  end

  assign slot_sel     = sel_q;
  assign sdram_rd     = rd_q;
  assign sdram_wr     = wr_q;
  assign sdram_addr   = addr_q;
  assign data_write   = dout_q;
  assign sdram_wrmask = mask_q;
  assign timeout      = to_q;
  assign timeout_slot = to_slot_q;

endmodule

// File: tb/tb_jtframe_ram_nslots_arb.sv
// Bench for jtframe_ram_nslots_arb: two instances share all inputs, one in
// fixed-priority mode and one in round-robin mode, both with a 16-cycle
// watchdog. A transaction-level reference model tracks each instance.
module tb_jtframe_ram_nslots_arb;
  localparam int N   = 8;
  localparam int AW  = 22;
  localparam int WRS = 2;
  localparam int TO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N-1:0]  req, rnw;
  logic [AW-1:0] t_addr [N];
  logic [15:0]   t_din  [N];
  logic [1:0]    t_mask [N];
  logic          ack, rdy;

  logic [N*AW-1:0] slot_addr;
  logic [N*16-1:0] slot_din;
  logic [N*2-1:0]  slot_wrmask;

  always_comb begin
    slot_addr   = '0;
    slot_din    = '0;
    slot_wrmask = '0;
    for (int i = 0; i < N; i++) begin
      slot_addr[i*AW +: AW] = t_addr[i];
      slot_din[i*16 +: 16]  = t_din[i];
      slot_wrmask[i*2 +: 2] = t_mask[i];
    end
  end

  // Index 0: fixed priority, index 1: round-robin
  logic [N-1:0]  o_sel  [2];
  logic          o_rd   [2];
  logic          o_wr   [2];
  logic [AW-1:0] o_addr [2];
  logic [15:0]   o_dout [2];
  logic [1:0]    o_mask [2];
  logic          o_to   [2];
  logic [2:0]    o_tos  [2];

  jtframe_ram_nslots_arb #(.SLOTS(N), .SDRAMW(AW), .WRSLOTS(WRS), .RR(0), .TIMEOUT(TO)) dut_fx (
    .clk(clk), .rst_n(rst_n), .slot_req(req), .slot_rnw(rnw), .slot_addr(slot_addr),
    .slot_din(slot_din), .slot_wrmask(slot_wrmask), .slot_sel(o_sel[0]),
    .sdram_ack(ack), .data_rdy(rdy), .sdram_rd(o_rd[0]), .sdram_wr(o_wr[0]),
    .sdram_addr(o_addr[0]), .data_write(o_dout[0]), .sdram_wrmask(o_mask[0]),
    .timeout(o_to[0]), .timeout_slot(o_tos[0]));

  jtframe_ram_nslots_arb #(.SLOTS(N), .SDRAMW(AW), .WRSLOTS(WRS), .RR(1), .TIMEOUT(TO)) dut_rr (
    .clk(clk), .rst_n(rst_n), .slot_req(req), .slot_rnw(rnw), .slot_addr(slot_addr),
    .slot_din(slot_din), .slot_wrmask(slot_wrmask), .slot_sel(o_sel[1]),
    .sdram_ack(ack), .data_rdy(rdy), .sdram_rd(o_rd[1]), .sdram_wr(o_wr[1]),
    .sdram_addr(o_addr[1]), .data_write(o_dout[1]), .sdram_wrmask(o_mask[1]),
    .timeout(o_to[1]), .timeout_slot(o_tos[1]));

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Reference model: granted slot (-1 = none) and the command it issued.
  int            m_g    [2];
  bit            m_rd   [2];
  bit            m_wr   [2];
  logic [AW-1:0] m_addr [2];
  logic [15:0]   m_dout [2];
  logic [1:0]    m_mask [2];
  bit            m_to   [2];
  int            m_tos  [2];
  int            m_ptr  [2];
  int            m_wait [2];   // cycles the current grant has been waiting

  task automatic model_step(input int m);
    int w;
    if (!rst_n) begin
      m_g[m] = -1; m_rd[m] = 0; m_wr[m] = 0; m_addr[m] = '0; m_dout[m] = '0;
      m_mask[m] = 2'b11; m_to[m] = 0; m_tos[m] = 0; m_ptr[m] = N - 1; m_wait[m] = 0;
      return;
    end
    m_to[m] = 0;
    if (ack) begin m_rd[m] = 0; m_wr[m] = 0; end
    if (m_g[m] < 0 || rdy) begin
      // Choose among requesting slots other than the one being finished.
      w = -1;
      for (int k = 0; k < N; k++) begin
        int s;
        s = (m == 1) ? (m_ptr[m] + 1 + k) % N : k;
        if (req[s] && s != m_g[m]) begin w = s; break; end
      end
      m_g[m] = w; m_rd[m] = 0; m_wr[m] = 0;
      if (w >= 0) begin
        m_addr[m] = t_addr[w];
        if (w < WRS) begin
          m_dout[m] = t_din[w]; m_mask[m] = t_mask[w];
          m_rd[m] = rnw[w]; m_wr[m] = !rnw[w];
        end else begin
          m_mask[m] = 2'b11; m_rd[m] = 1;
        end
        m_wait[m] = 0;
        if (m == 1) m_ptr[m] = w;
      end
    end else begin
      m_wait[m]++;
      if (m_wait[m] == TO) begin
        m_to[m] = 1; m_tos[m] = m_g[m]; m_g[m] = -1; m_rd[m] = 0; m_wr[m] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    for (int m = 0; m < 2; m++) begin
      string p;
      logic [N-1:0] es;
      p  = (m == 0) ? "fx" : "rr";
      es = (m_g[m] < 0) ? '0 : N'(1) << m_g[m];
      chk({p, ".sel"},  32'(o_sel[m]),  32'(es));
      chk({p, ".rd"},   32'(o_rd[m]),   32'(m_rd[m]));
      chk({p, ".wr"},   32'(o_wr[m]),   32'(m_wr[m]));
      chk({p, ".addr"}, 32'(o_addr[m]), 32'(m_addr[m]));
      chk({p, ".dout"}, 32'(o_dout[m]), 32'(m_dout[m]));
      chk({p, ".mask"}, 32'(o_mask[m]), 32'(m_mask[m]));
      chk({p, ".to"},   32'(o_to[m]),   32'(m_to[m]));
      chk({p, ".tos"},  32'(o_tos[m]),  32'(m_tos[m]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL bench_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; req = '0; rnw = '1; ack = 1'b0; rdy = 1'b0;
    for (int i = 0; i < N; i++) begin t_addr[i] = '0; t_din[i] = '0; t_mask[i] = '0; end
    for (int m = 0; m < 2; m++) m_g[m] = -1;

    // Reset values
    tick(); tick();
    chk("rst.sel", 32'(o_sel[0]), 32'h0);
    chk("rst.mask", 32'(o_mask[0]), 32'h3);
    chk("rst.addr", 32'(o_addr[0]), 32'h0);
    chk("rst.to", 32'(o_to[0]), 32'h0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle.sel", 32'(o_sel[0]), 32'h0);
    chk("idle.rd", 32'(o_rd[0]), 32'h0);

    // First grant one edge after the request
    t_addr[2] = 22'h1234; req = 8'h04;
    tick();
    chk("g2.sel", 32'(o_sel[0]), 32'h04);
    chk("g2.rd", 32'(o_rd[0]), 32'h1);
    chk("g2.addr", 32'(o_addr[0]), 32'h1234);
    chk("g2.sel_rr", 32'(o_sel[1]), 32'h04);
    // ack drops the strobe, grant held until data_rdy
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack.rd", 32'(o_rd[0]), 32'h0);
    chk("ack.sel", 32'(o_sel[0]), 32'h04);
    tick();
    chk("hold.sel", 32'(o_sel[0]), 32'h04);
    rdy = 1'b1; req = '0; tick(); rdy = 1'b0;
    chk("end.sel", 32'(o_sel[0]), 32'h0);

    // Fixed priority: slots 1 and 3
    t_addr[1] = 22'h111; t_addr[3] = 22'h333; req = 8'h0A;
    tick();
    chk("fx.first", 32'(o_sel[0]), 32'h02);
    rdy = 1'b1;
    tick(); chk("fx.second", 32'(o_sel[0]), 32'h08);
    chk("fx.addr3", 32'(o_addr[0]), 32'h333);
    tick(); chk("fx.again", 32'(o_sel[0]), 32'h02);
    tick(); chk("fx.again3", 32'(o_sel[0]), 32'h08);
    req = '0; tick(); rdy = 1'b0; tick();

    // Round-robin sweep with data_rdy two cycles after each grant
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 8'hFF;
    tick();
    chk("rr.g0", 32'(o_sel[1]), 32'h01);
    for (int k = 0; k < N; k++) begin
      rdy = 1'b0; tick();
      chk($sformatf("rr.hold%0d", k), 32'(o_sel[1]), 32'(8'h1 << k));
      rdy = 1'b1; tick();
      chk($sformatf("rr.next%0d", k), 32'(o_sel[1]), 32'(8'h1 << ((k + 1) % N)));
    end
    req = '0; tick(); rdy = 1'b0; tick();

    // Writes
    rnw[0] = 1'b0; t_din[0] = 16'hBEEF; t_mask[0] = 2'b01; req = 8'h01;
    tick();
    chk("wr0.wr", 32'(o_wr[0]), 32'h1);
    chk("wr0.rd", 32'(o_rd[0]), 32'h0);
    chk("wr0.dout", 32'(o_dout[0]), 32'hBEEF);
    chk("wr0.mask", 32'(o_mask[0]), 32'h1);
    rdy = 1'b1; req = '0; tick(); rdy = 1'b0;
    rnw[5] = 1'b0; t_din[5] = 16'h5555; t_mask[5] = 2'b00; t_addr[5] = 22'h2AAAA; req = 8'h20;
    tick();
    chk("ro5.sel", 32'(o_sel[0]), 32'h20);
    chk("ro5.rd", 32'(o_rd[0]), 32'h1);
    chk("ro5.wr", 32'(o_wr[0]), 32'h0);
    chk("ro5.mask", 32'(o_mask[0]), 32'h3);
    chk("ro5.dout", 32'(o_dout[0]), 32'hBEEF);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ro5.ackrd", 32'(o_rd[0]), 32'h0);
    chk("ro5.acksel", 32'(o_sel[0]), 32'h20);
    rdy = 1'b1; req = '0; tick(); rdy = 1'b0; tick();

    // Watchdog: slot 3 never completes, slot 6 waits
    rnw[3] = 1'b1; req = 8'h08;
    tick();
    chk("wd.grant", 32'(o_sel[0]), 32'h08);
    req = 8'h48;
    for (int j = 1; j < TO; j++) begin
      tick();
      chk($sformatf("wd.wait%0d", j), 32'(o_to[0]), 32'h0);
    end
    chk("wd.held", 32'(o_sel[0]), 32'h08);
    tick();
    chk("wd.pulse", 32'(o_to[0]), 32'h1);
    chk("wd.slot", 32'(o_tos[0]), 32'h3);
    chk("wd.sel", 32'(o_sel[0]), 32'h0);
    chk("wd.pulse_rr", 32'(o_to[1]), 32'h1);
    req = 8'h40;
    tick();
    chk("wd.next", 32'(o_sel[0]), 32'h40);
    chk("wd.next_rr", 32'(o_sel[1]), 32'h40);
    chk("wd.clr", 32'(o_to[0]), 32'h0);
    rdy = 1'b1; req = '0; tick(); rdy = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 900; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          t_addr[i] = AW'($urandom); t_din[i] = 16'($urandom); t_mask[i] = 2'($urandom);
        end
      end
      rnw = N'($urandom);
      if ($urandom_range(0, 2) == 0) req = N'($urandom) & N'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      rdy = (c < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
